// File: rtl/pseudo_spi_xfer_engine_if.sv
// rtl/pseudo_spi_xfer_engine_if.sv - SRAM-side bus bundle for the pseudo-SPI transfer engine
interface pseudo_spi_xfer_engine_if #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10
) ();
    logic [MEMORY_ADDR_WIDTH-1:0] A;
    logic [MEMORY_DATA_WIDTH-1:0] PO;
    logic [MEMORY_DATA_WIDTH-1:0] PI;
    logic                         CEN;
    logic                         D_WE;

    // Engine side drives address/data/strobes and receives read data
    modport master (output A, PO, CEN, D_WE, input PI);
    // Memory side
    modport slave  (input A, PO, CEN, D_WE, output PI);
endinterface

// File: rtl/pseudo_spi_xfer_engine.sv
// rtl/pseudo_spi_xfer_engine.sv - SRAM <-> two-phase serial word transfer engine
module pseudo_spi_xfer_engine #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int RESERVED_DATA_LEN = 8,
    parameter int DIV_WIDTH         = 8
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic                         BGN,
    input  logic                         MODE,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic [DIV_WIDTH-1:0]         FREQ_DIV,
    input  logic [MEMORY_DATA_WIDTH-1:0] PI,
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         LAT,
    output logic                         SPI_SO,
    output logic                         CEN,
    output logic                         D_WE,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] PO,
    output logic                         spi_MUX,
    output logic                         spi_is_done
);
    localparam int W  = MEMORY_DATA_WIDTH;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int LW = RESERVED_DATA_LEN;
    localparam int VW = DIV_WIDTH;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ADDR  = 3'b001,
        READ  = 3'b011,
        SOUT  = 3'b010,
        LOOP  = 3'b110,
        RDY   = 3'b100,
        DONE  = 3'b101,
        WRITE = 3'b111
    } state_t;

    state_t          state_q;
    logic            mode_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   len_q;
    logic [VW-1:0]   div_q;
    logic [VW-1:0]   cnt_q;
    logic [VW-1:0]   cnt_d;
    logic [1:0]      phase_q;
    logic [1:0]      phase_d;
    logic            phase_end;
    logic [BW-1:0]   bit_cnt_q;
    logic [W-1:0]    shift_q;
    logic            bgn_prev_q;
    logic            sclk1_q, sclk2_q, lat_q, so_q, cen_q, we_q, mux_q, done_q;
    logic [AW-1:0]   a_q;
    logic [W-1:0]    po_q;

    // Phase timer: each phase lasts div_q+1 cycles, phases wrap 0..3
    always_comb begin
        phase_end = (cnt_q == div_q);
        cnt_d     = phase_end ? '0 : cnt_q + VW'(1);
        phase_d   = phase_end ? phase_q + 2'd1 : phase_q;
    end

    // Transfer FSM with all outputs registered on the transition into each state
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            phase_q    <= 2'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            bgn_prev_q <= 1'b1;   // a level-high BGN at reset release is not an edge
            sclk1_q    <= 1'b0;
            sclk2_q    <= 1'b0;
            lat_q      <= 1'b0;
            so_q       <= 1'b0;
            cen_q      <= 1'b1;
            we_q       <= 1'b1;
            mux_q      <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= '0;
            po_q       <= '0;
        end else begin
            bgn_prev_q <= BGN;
            cen_q      <= 1'b1;   // SRAM strobes last exactly one cycle
            we_q       <= 1'b1;
            if ((state_q != IDLE) && (state_q != DONE) && !BGN) begin
                state_q   <= IDLE;
                sclk1_q   <= 1'b0;
                sclk2_q   <= 1'b0;
                lat_q     <= 1'b0;
                so_q      <= 1'b0;
                mux_q     <= 1'b0;
                cnt_q     <= '0;
                phase_q   <= 2'd0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (BGN && !bgn_prev_q) begin
                            mode_q    <= MODE;
                            div_q     <= FREQ_DIV;
                            addr_q    <= ADDR_BGN + AW'(1);
                            len_q     <= DATA_LEN;
                            cnt_q     <= '0;
                            phase_q   <= 2'd0;
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                            if (DATA_LEN == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                mux_q <= 1'b1;
                                if (!MODE) begin
                                    state_q <= ADDR;
                                    a_q     <= ADDR_BGN + AW'(1);
                                    cen_q   <= 1'b0;
                                end else begin
                                    state_q <= LOOP;
                                    sclk1_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR: state_q <= READ;
                    READ: begin
                        shift_q <= PI;
                        state_q <= SOUT;
                    end
                    SOUT: begin
                        so_q    <= shift_q[0];
                        sclk1_q <= 1'b1;
                        cnt_q   <= '0;
                        phase_q <= 2'd0;
                        state_q <= LOOP;
                    end
                    LOOP: begin
                        cnt_q <= cnt_d;
                        if (lat_q) begin
                            // Latch phase after the last bit of the word
                            if (phase_end) begin
                                lat_q <= 1'b0;
                                if (mode_q) begin
                                    state_q <= WRITE;
                                    a_q     <= addr_q;
                                    po_q    <= shift_q;
                                    cen_q   <= 1'b0;
                                    we_q    <= 1'b0;
                                end else begin
                                    state_q <= RDY;
                                end
                            end
                        end else begin
                            phase_q <= phase_d;
                            sclk2_q <= (phase_d == 2'd2);
                            if (mode_q && (phase_q == 2'd2) && phase_end) begin
                                shift_q <= {SPI_SI, shift_q[W-1:1]};
                            end
                            if ((phase_q == 2'd3) && phase_end) begin
                                if (bit_cnt_q == LAST_BIT) begin
                                    bit_cnt_q <= '0;
                                    sclk1_q   <= 1'b0;
                                    lat_q     <= 1'b1;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + BW'(1);
                                    sclk1_q   <= 1'b1;
                                    if (!mode_q) begin
                                        shift_q <= shift_q >> 1;
                                        so_q    <= shift_q[1];
                                    end
                                end
                            end else begin
                                sclk1_q <= (phase_d == 2'd0);
                            end
                        end
                    end
                    WRITE: state_q <= RDY;
                    RDY: begin
                        len_q <= len_q - LW'(1);
                        if (len_q == LW'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            mux_q   <= 1'b0;
                            so_q    <= 1'b0;
                        end else begin
                            addr_q  <= addr_q + AW'(1);
                            cnt_q   <= '0;
                            phase_q <= 2'd0;
                            if (mode_q) begin
                                state_q <= LOOP;
                                sclk1_q <= 1'b1;
                            end else begin
                                state_q <= ADDR;
                                a_q     <= addr_q + AW'(1);
                                cen_q   <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        if (!BGN) begin
                            state_q <= IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign SCLK1       = sclk1_q;
    assign SCLK2       = sclk2_q;
    assign LAT         = lat_q;
    assign SPI_SO      = so_q;
    assign CEN         = cen_q;
    assign D_WE        = we_q;
    assign A           = a_q;
    assign PO          = po_q;
    assign spi_MUX     = mux_q;
    assign spi_is_done = done_q;
endmodule

// File: doc/pseudo_spi_xfer_engine.md
PSEUDO_SPI_XFER_ENGINE -- requirements
Module: pseudo_spi_xfer_engine

Interface
REQ-001 SHALL have parameter MEMORY_DATA_WIDTH, default 8, SRAM word width and bits per serial word.
REQ-002 SHALL have parameter MEMORY_ADDR_WIDTH, default 10, SRAM address width.
REQ-003 SHALL have parameter RESERVED_DATA_LEN, default 8, width of the word-count input.
REQ-004 SHALL have parameter DIV_WIDTH, default 8, width of the clock-divider input.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port BGN, input, 1 bit, level enable; rising edge in IDLE starts a transfer.
REQ-008 SHALL have port MODE, input, 1 bit, 0 = SRAM->serial readout, 1 = serial->SRAM load.
REQ-009 SHALL have port ADDR_BGN, input, MEMORY_ADDR_WIDTH, base address; first word accessed is ADDR_BGN+1.
REQ-010 SHALL have port DATA_LEN, input, RESERVED_DATA_LEN, number of words to transfer.
REQ-011 SHALL have port FREQ_DIV, input, DIV_WIDTH, phase length minus one in CLK cycles.
REQ-012 SHALL have port PI, input, MEMORY_DATA_WIDTH, SRAM Q data.
REQ-013 SHALL have port SPI_SI, input, 1 bit, serial data in (MODE=1).
REQ-014 SHALL have ports SCLK1, SCLK2, LAT, SPI_SO, output, 1 bit each: two-phase serial clocks, word latch strobe, serial data out.
REQ-015 SHALL have ports CEN and D_WE, output, 1 bit each, SRAM chip enable and write enable, both active-low.
REQ-016 SHALL have ports A (MEMORY_ADDR_WIDTH) and PO (MEMORY_DATA_WIDTH), output, SRAM address and write data.
REQ-017 SHALL have ports spi_MUX and spi_is_done, output, 1 bit each: SRAM-bus ownership request, transfer complete.

Function
REQ-018 SHALL implement states IDLE, ADDR, READ, SOUT, LOOP, RDY, WRITE, DONE; encodings IDLE=000 ADDR=001 READ=011 SOUT=010 LOOP=110 RDY=100 DONE=101, WRITE=111.
REQ-019 SHALL latch MODE, ADDR_BGN, DATA_LEN, FREQ_DIV on leaving IDLE; later input changes ignored until next start.
REQ-020 SHALL go IDLE->DONE directly when latched DATA_LEN=0, without asserting CEN.
REQ-021 Word address SHALL be ADDR_BGN+1+n for word n, modulo 2^MEMORY_ADDR_WIDTH (wraps from max to 0).
REQ-022 Bit slot SHALL be four phases of FREQ_DIV+1 CLK cycles each: P0 SCLK1=1, P1 both low, P2 SCLK2=1, P3 both low; SCLK1 and SCLK2 never high together.
REQ-023 MODE=0: ADDR drives A with CEN=0, D_WE=1 for one cycle; READ captures PI into shift register on next cycle; SOUT/LOOP shift LSB first, SPI_SO updated at start of P0.
REQ-024 MODE=1: LOOP samples SPI_SI at last cycle of P2 into shift register MSB, shifting right; after MEMORY_DATA_WIDTH bits WRITE drives A, PO, CEN=0, D_WE=0 for exactly one cycle.
REQ-025 LAT SHALL pulse high for one full phase (P0 timing) after the last bit of each word, in both modes.
REQ-026 RDY SHALL decrement remaining count; nonzero -> ADDR (MODE=0) or LOOP (MODE=1); zero -> DONE.
REQ-027 spi_MUX SHALL be 1 in every state except IDLE and DONE.
REQ-028 spi_is_done SHALL be 1 in DONE; DONE holds while BGN=1 and returns to IDLE one cycle after BGN=0.
REQ-029 BGN=0 in any non-IDLE, non-DONE state SHALL abort: next cycle IDLE, CEN=1, D_WE=1, serial outputs low, no partial word written.
REQ-030 Outside ADDR/WRITE cycles CEN=1 and D_WE=1.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, CEN=1, D_WE=1, A=0, PO=0, SCLK1=SCLK2=LAT=SPI_SO=0, spi_MUX=0, spi_is_done=0, counters and shift register cleared, including mid-transfer.
REQ-032 After rst_n release, BGN already high SHALL NOT start a transfer; a fresh 0->1 edge is required.

Verification
REQ-033 MODE=0, ADDR_BGN=31, DATA_LEN=14, FREQ_DIV=0, SRAM 32..45 preloaded 0xAB,0x00,0x00,0x3C,... -> 14 words LSB first on SPI_SO sampled at SCLK2, addresses 32..45, 14 LAT pulses, spi_is_done=1.
REQ-034 MODE=1, ADDR_BGN=1023, DATA_LEN=2, FREQ_DIV=3, SPI_SI streams 0x5A then 0xC3 LSB first -> SRAM[0]=0x5A, SRAM[1]=0xC3, each write a single cycle with CEN=D_WE=0, slot = 16 CLK.
REQ-035 DATA_LEN=0 -> spi_is_done=1 within 2 cycles, CEN never 0.
REQ-036 BGN dropped during bit 4 of word 2 (MODE=1) -> IDLE next cycle, SRAM word 2 unchanged, spi_MUX=0.
REQ-037 rst_n pulsed low mid-LOOP -> all outputs at reset values same timestep; restart with new BGN edge completes normally.
REQ-038 Assertion throughout: SCLK1&SCLK2 never 1; CEN=0 only in ADDR/WRITE.
